// File: rtl/fetch_unit.sv
// Instruction-fetch stage: reads memory at the PC, holds the word for decode
// behind a valid/ready handshake, and strobes the pc block to advance or redirect.
module fetch_unit #(
  parameter int unsigned P_ADDRESS_WIDTH = 16,
  parameter int unsigned P_DATA_WIDTH    = 16
) (
  input  logic                       I_CLOCK,
  input  logic                       I_RESET,
  input  logic [P_ADDRESS_WIDTH-1:0] I_PC_ADDRESS,
  output logic                       O_PC_ENABLE,
  output logic [P_ADDRESS_WIDTH-1:0] O_PC_ADDRESS,
  output logic                       O_PC_ADDRESS_SELECT,
  output logic                       O_PC_ADDRESS_SELECT_INCREMENT,
  output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
  output logic                       O_MEM_READ,
  input  logic [P_DATA_WIDTH-1:0]    I_MEM_DATA,
  output logic [P_DATA_WIDTH-1:0]    O_INSTRUCTION,
  output logic [P_ADDRESS_WIDTH-1:0] O_INSTRUCTION_ADDRESS,
  output logic                       O_VALID,
  input  logic                       I_READY,
  input  logic                       I_REDIRECT,
  input  logic [1:0]                 I_REDIRECT_MODE,
  input  logic [P_ADDRESS_WIDTH-1:0] I_REDIRECT_ADDRESS
);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DEFER,
    ST_REDIRECT
  } state_e;

  state_e                     state_q, state_d;
  logic [P_ADDRESS_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [P_ADDRESS_WIDTH-1:0] accepted_addr_q, accepted_addr_d;
  logic [P_ADDRESS_WIDTH-1:0] pc_addr_q, pc_addr_d;
  logic                       pc_en_q, pc_en_d;
  logic                       pc_sel_q, pc_sel_d;
  logic                       pc_inc_q, pc_inc_d;
  logic [P_DATA_WIDTH-1:0]    instr_q, instr_d;
  logic [P_ADDRESS_WIDTH-1:0] instr_addr_q, instr_addr_d;
  logic                       valid_q, valid_d;
  logic [P_ADDRESS_WIDTH-1:0] target;
  logic                       redirect_ok;

  always_comb begin
    state_d         = state_q;
    fetch_addr_d    = fetch_addr_q;
    accepted_addr_d = accepted_addr_q;
    pc_addr_d       = pc_addr_q;
    pc_en_d         = pc_en_q;
    pc_sel_d        = pc_sel_q;
    pc_inc_d        = pc_inc_q;
    instr_d         = instr_q;
    instr_addr_d    = instr_addr_q;
    valid_d         = valid_q;

    redirect_ok = I_REDIRECT &&
                  (state_q == ST_FETCH || state_q == ST_WAIT || state_q == ST_HOLD);

    unique case (I_REDIRECT_MODE)
      2'd1:    target = accepted_addr_q + I_REDIRECT_ADDRESS;
      default: target = I_REDIRECT_ADDRESS;
    endcase

    unique case (state_q)
      ST_FETCH: begin
        fetch_addr_d = I_PC_ADDRESS;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        // A redirect discards the returned word, so only load it otherwise.
        if (!redirect_ok) begin
          instr_d      = I_MEM_DATA;
          instr_addr_d = fetch_addr_q;
        end
        valid_d  = 1'b1;
        pc_en_d  = 1'b1;
        pc_sel_d = 1'b0;
        pc_inc_d = 1'b0;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        pc_en_d = 1'b0;
        if (valid_q && I_READY) begin
          valid_d         = 1'b0;
          accepted_addr_d = instr_addr_q;
          state_d         = ST_FETCH;
        end
      end
      ST_DEFER: begin
        pc_en_d = 1'b1;
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        pc_en_d  = 1'b0;
        pc_sel_d = 1'b0;
        pc_inc_d = 1'b0;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // Redirect overrides the per-state updates; while the increment strobe is
    // still high it is deferred one cycle so each pulse stays isolated.
    if (redirect_ok) begin
      pc_addr_d = target;
      pc_sel_d  = 1'b1;
      pc_inc_d  = (I_REDIRECT_MODE == 2'd2);
      valid_d   = 1'b0;
      if (pc_en_q) begin
        pc_en_d = 1'b0;
        state_d = ST_DEFER;
      end else begin
        pc_en_d = 1'b1;
        state_d = ST_REDIRECT;
      end
    end
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      state_q         <= ST_FETCH;
      fetch_addr_q    <= '0;
      accepted_addr_q <= '0;
      pc_addr_q       <= '0;
      pc_en_q         <= 1'b0;
      pc_sel_q        <= 1'b0;
      pc_inc_q        <= 1'b0;
      instr_q         <= '0;
      instr_addr_q    <= '0;
      valid_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_addr_q    <= fetch_addr_d;
      accepted_addr_q <= accepted_addr_d;
      pc_addr_q       <= pc_addr_d;
      pc_en_q         <= pc_en_d;
      pc_sel_q        <= pc_sel_d;
      pc_inc_q        <= pc_inc_d;
      instr_q         <= instr_d;
      instr_addr_q    <= instr_addr_d;
      valid_q         <= valid_d;
    end
  end

  assign O_MEM_ADDRESS                 = I_PC_ADDRESS;
  assign O_MEM_READ                    = (state_q == ST_FETCH);
  assign O_PC_ENABLE                   = pc_en_q;
  assign O_PC_ADDRESS                  = pc_addr_q;
  assign O_PC_ADDRESS_SELECT           = pc_sel_q;
  assign O_PC_ADDRESS_SELECT_INCREMENT = pc_inc_q;
  assign O_INSTRUCTION                 = instr_q;
  assign O_INSTRUCTION_ADDRESS         = instr_addr_q;
  assign O_VALID                       = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural pc block and synchronous memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        pc_en;
  logic [15:0] pc_addr;
  logic        pc_sel;
  logic        pc_inc;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic [15:0] instr_addr;
  logic        valid;
  logic        ready;
  logic        redirect;
  logic [1:0]  redirect_mode;
  logic [15:0] redirect_addr;

  logic [15:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.P_ADDRESS_WIDTH(16), .P_DATA_WIDTH(16)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_PC_ADDRESS(pc),
    .O_PC_ENABLE(pc_en), .O_PC_ADDRESS(pc_addr), .O_PC_ADDRESS_SELECT(pc_sel),
    .O_PC_ADDRESS_SELECT_INCREMENT(pc_inc), .O_MEM_ADDRESS(mem_addr),
    .O_MEM_READ(mem_read), .I_MEM_DATA(mem_data), .O_INSTRUCTION(instr),
    .O_INSTRUCTION_ADDRESS(instr_addr), .O_VALID(valid), .I_READY(ready),
    .I_REDIRECT(redirect), .I_REDIRECT_MODE(redirect_mode),
    .I_REDIRECT_ADDRESS(redirect_addr)
  );

  // pc block: reset via I_NRESET = ~I_RESET, updates while enabled.
  always @(posedge clk) begin
    if (rst) pc <= 16'h0000;
    else if (pc_en) pc <= pc_sel ? (pc_addr + {15'd0, pc_inc}) : (pc + 16'd1);
  end

  always @(posedge clk) begin
    if (mem_read) mem_data <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (!rst && redirect && pc_sel) begin
      errors++;
      $display("FAIL protocol: redirect driven during defer/redirect (sel=%b)", pc_sel);
    end
  end

  logic en_prev = 1'b0;
  always @(negedge clk) begin
    if (en_prev && pc_en) begin
      errors++;
      $display("FAIL pulse_width: O_PC_ENABLE high two cycles in a row");
    end
    en_prev <= pc_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid === 1'b1) break;
    end
    if (valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: O_VALID=%b, required 1 within 12 cycles", name, valid);
    end
  endtask

  task automatic check_fetch(input string name, input logic [15:0] exp_addr,
                             input logic [15:0] exp_instr);
    checks++;
    if (instr_addr !== exp_addr) begin
      errors++;
      $display("FAIL %s_addr: got %h want %h", name, instr_addr, exp_addr);
    end
    checks++;
    if (instr !== exp_instr) begin
      errors++;
      $display("FAIL %s_instr: got %h want %h", name, instr, exp_instr);
    end
  endtask

  task automatic test_reset();
    ready = 1'b1;
    redirect_mode = 2'd0;
    redirect_addr = 16'h0000;
    rst = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    checks++;
    if ({valid, pc_en, pc_sel, pc_inc} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {valid, pc_en, pc_sel, pc_inc});
    end
    checks++;
    if ({instr, instr_addr, pc_addr} !== 48'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h want 0", {instr, instr_addr, pc_addr});
    end
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL seq_early_valid: got %b want 0", valid);
    end
    tick();
    checks++;
    if ({valid, pc_en} !== 2'b11) begin
      errors++; $display("FAIL seq_first_valid: valid,en got %b want 11", {valid, pc_en});
    end
    check_fetch("seq0", 16'h0000, 16'h1234);
    tick();
    checks++;
    if ({valid, pc_en, pc} !== {2'b00, 16'h0001}) begin
      errors++; $display("FAIL seq_accept: valid,en,pc got %b %b %h want 0 0 0001", valid, pc_en, pc);
    end
    tick();
    tick();
    checks++;
    if (valid !== 1'b1) begin
      errors++; $display("FAIL seq_second_valid: got %b want 1", valid);
    end
    check_fetch("seq1", 16'h0001, 16'hABCD);
    tick();
    checks++;
    if (pc !== 16'h0002) begin
      errors++; $display("FAIL seq_pc: got %h want 0002", pc);
    end
  endtask

  task automatic test_stall();
    int pulses;
    ready = 1'b0;
    do_reset();
    tick();
    tick();
    pulses = (pc_en === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pc_en === 1'b1) pulses++;
      checks++;
      if ({valid, mem_read, instr, instr_addr} !== {2'b10, 16'h1234, 16'h0000}) begin
        errors++;
        $display("FAIL stall_hold: valid,rd,instr,addr got %b %b %h %h want 1 0 1234 0000",
                 valid, mem_read, instr, instr_addr);
      end
    end
    checks++;
    if (pulses != 1 || pc !== 16'h0001) begin
      errors++; $display("FAIL stall_pc: pulses %0d pc %h want 1 0001", pulses, pc);
    end
    ready = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: got %b want 0", valid);
    end
  endtask

  task automatic test_redirect_abs();
    ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    redirect = 1'b1; redirect_mode = 2'd0; redirect_addr = 16'h0040;
    tick();
    redirect = 1'b0;
    checks++;
    if ({pc_en, pc_sel, pc_inc, valid, pc_addr} !== {4'b1100, 16'h0040}) begin
      errors++;
      $display("FAIL abs_pulse: en,sel,inc,valid,addr got %b%b%b%b %h want 1100 0040",
               pc_en, pc_sel, pc_inc, valid, pc_addr);
    end
    tick();
    checks++;
    if ({pc_en, pc_sel, pc} !== {2'b00, 16'h0040}) begin
      errors++; $display("FAIL abs_pc: en,sel,pc got %b%b %h want 00 0040", pc_en, pc_sel, pc);
    end
    ready = 1'b1;
    wait_valid("abs");
    check_fetch("abs", 16'h0040, 16'hA5E5);
    tick();
    redirect = 1'b1; redirect_mode = 2'd2; redirect_addr = 16'h0030;
    tick();
    redirect = 1'b0;
    checks++;
    if ({pc_sel, pc_inc} !== 2'b11) begin
      errors++; $display("FAIL inc_sel: sel,inc got %b want 11", {pc_sel, pc_inc});
    end
    wait_valid("inc");
    check_fetch("inc", 16'h0031, 16'hA594);
  endtask

  task automatic test_redirect_rel();
    tick();
    redirect = 1'b1; redirect_mode = 2'd0; redirect_addr = 16'h0010;
    tick();
    redirect = 1'b0;
    wait_valid("rel_setup");
    check_fetch("rel_setup", 16'h0010, 16'hA5B5);
    tick();
    redirect = 1'b1; redirect_mode = 2'd1; redirect_addr = 16'hFFFC;
    tick();
    redirect = 1'b0;
    checks++;
    if (pc_addr !== 16'h000C) begin
      errors++; $display("FAIL rel_target: got %h want 000C", pc_addr);
    end
    wait_valid("rel");
    check_fetch("rel", 16'h000C, 16'hA5A9);
    tick();
    redirect = 1'b1; redirect_mode = 2'd3; redirect_addr = 16'hFFFE;
    tick();
    redirect = 1'b0;
    checks++;
    if ({pc_inc, pc_addr} !== {1'b0, 16'hFFFE}) begin
      errors++; $display("FAIL mode3: inc,addr got %b %h want 0 FFFE", pc_inc, pc_addr);
    end
    wait_valid("mode3");
    check_fetch("mode3", 16'hFFFE, 16'h5A5B);
    tick();
    redirect = 1'b1; redirect_mode = 2'd1; redirect_addr = 16'h0004;
    tick();
    redirect = 1'b0;
    wait_valid("wrap");
    check_fetch("wrap", 16'h0002, 16'hA5A7);
  endtask

  task automatic test_defer();
    ready = 1'b0;
    do_reset();
    tick();
    tick();
    redirect = 1'b1; redirect_mode = 2'd0; redirect_addr = 16'h0020;
    tick();
    redirect = 1'b0;
    checks++;
    if ({pc_en, pc_sel, valid, pc_addr, pc} !== {3'b010, 16'h0020, 16'h0001}) begin
      errors++;
      $display("FAIL defer_low: en,sel,valid,addr,pc got %b%b%b %h %h want 010 0020 0001",
               pc_en, pc_sel, valid, pc_addr, pc);
    end
    tick();
    checks++;
    if (pc_en !== 1'b1) begin
      errors++; $display("FAIL defer_pulse: got %b want 1", pc_en);
    end
    tick();
    checks++;
    if ({pc_en, pc} !== {1'b0, 16'h0020}) begin
      errors++; $display("FAIL defer_pc: en,pc got %b %h want 0 0020", pc_en, pc);
    end
    ready = 1'b1;
    wait_valid("defer");
    check_fetch("defer", 16'h0020, 16'hA585);
  endtask

  task automatic test_redirect_in_wait();
    ready = 1'b1;
    do_reset();
    tick();
    redirect = 1'b1; redirect_mode = 2'd0; redirect_addr = 16'h0050;
    tick();
    redirect = 1'b0;
    checks++;
    if ({valid, pc_en, instr} !== {2'b01, 16'h0000}) begin
      errors++;
      $display("FAIL wait_discard: valid,en,instr got %b%b %h want 01 0000", valid, pc_en, instr);
    end
    tick();
    checks++;
    if ({valid, pc} !== {1'b0, 16'h0050}) begin
      errors++; $display("FAIL wait_pc: valid,pc got %b %h want 0 0050", valid, pc);
    end
    wait_valid("wait");
    check_fetch("wait", 16'h0050, 16'hA5F5);
  endtask

  task automatic test_reset_in_wait();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({valid, pc_en, pc_sel, pc_inc, instr, instr_addr, pc_addr} !== 52'h0) begin
      errors++;
      $display("FAIL rst_wait: flags %b regs %h %h %h want all 0",
               {valid, pc_en, pc_sel, pc_inc}, instr, instr_addr, pc_addr);
    end
    checks++;
    if ({mem_read, mem_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("FAIL rst_fetch: rd,addr got %b %h want 1 0000", mem_read, mem_addr);
    end
    wait_valid("rst_wait");
    check_fetch("rst_wait", 16'h0000, 16'h1234);
  endtask

  initial begin
    for (int unsigned i = 0; i < 65536; i++) mem[i] = i[15:0] ^ 16'hA5A5;
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    mem_data = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_abs();
    test_redirect_rel();
    test_defer();
    test_redirect_in_wait();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting between the `pc` block and the decode stage of the CR16 multicycle datapath.
- Reads the current PC value, issues a read to synchronous instruction memory, and latches the returned word into an instruction register.
- Presents that word to decode through a valid/ready handshake.
- Drives pc's enable strobe and address-select inputs to advance sequentially or take a redirect from execute.

Parameters:
- P_ADDRESS_WIDTH, 16, width of PC/memory addresses and redirect address.
- P_DATA_WIDTH, 16, width of instruction words.

Ports:
- I_CLOCK  in  1  system clock; all state updates on the rising edge.
- I_RESET  in  1  synchronous, active-high reset.
- I_PC_ADDRESS  in  P_ADDRESS_WIDTH  pc O_ADDRESS.
- O_PC_ENABLE  out  1  one-cycle registered strobe to pc I_ENABLE; pc updates on its rising edge.
- O_PC_ADDRESS  out  P_ADDRESS_WIDTH  to pc I_ADDRESS.
- O_PC_ADDRESS_SELECT  out  1  to pc I_ADDRESS_SELECT.
- O_PC_ADDRESS_SELECT_INCREMENT  out  1  to pc I_ADDRESS_SELECT_INCREMENT. pc I_ADDRESS_SELECT_DISPLACE is tied 0 at top level.
- O_MEM_ADDRESS  out  P_ADDRESS_WIDTH  instruction-memory read address.
- O_MEM_READ  out  1  read request.
- I_MEM_DATA  in  P_DATA_WIDTH  read data, valid the cycle after the request.
- O_INSTRUCTION  out  P_DATA_WIDTH  instruction register.
- O_INSTRUCTION_ADDRESS  out  P_ADDRESS_WIDTH  address of O_INSTRUCTION.
- O_VALID  out  1  instruction register holds an unconsumed instruction.
- I_READY  in  1  decode accepts; transfer when O_VALID and I_READY.
- I_REDIRECT  in  1  one-cycle redirect request from execute.
- I_REDIRECT_MODE  in  2  0 absolute, 1 relative, 2 absolute+1, 3 treated as 0.
- I_REDIRECT_ADDRESS  in  P_ADDRESS_WIDTH  target (modes 0/2) or two's-complement displacement (mode 1).

Behaviour:
- Reset: one clock (I_CLOCK); reset I_RESET is synchronous, active-high. Top level drives pc I_NRESET = ~I_RESET.
  - All outputs reset to 0; r_accepted_addr = 0; state = ST_FETCH.
  - Reset mid-operation (including while O_PC_ENABLE is high) aborts everything; no instruction is presented.
- Combinational outputs: O_MEM_ADDRESS = I_PC_ADDRESS; O_MEM_READ = (state == ST_FETCH). All other outputs are registered.
- ST_FETCH: capture r_fetch_addr <= I_PC_ADDRESS; go to ST_WAIT.
- ST_WAIT: on the next edge:
  - O_INSTRUCTION <= I_MEM_DATA; O_INSTRUCTION_ADDRESS <= r_fetch_addr; O_VALID <= 1.
  - O_PC_ENABLE <= 1 with both select outputs 0 (pc increments).
  - Go to ST_HOLD.
- ST_HOLD:
  - O_PC_ENABLE <= 0 unconditionally.
  - On O_VALID and I_READY: O_VALID <= 0; r_accepted_addr <= O_INSTRUCTION_ADDRESS; go to ST_FETCH.
  - Otherwise hold; O_INSTRUCTION and its address stay stable; no memory read.
- Throughput: 3 cycles per instruction with I_READY held high; first O_VALID appears 2 cycles after reset release.
- Redirect: I_REDIRECT has priority over all non-reset activity in ST_FETCH, ST_WAIT and ST_HOLD.
  - Target computation:
    - Mode 0: target = I_REDIRECT_ADDRESS, increment = 0.
    - Mode 2: target = I_REDIRECT_ADDRESS, increment = 1.
    - Mode 1: target = r_accepted_addr + I_REDIRECT_ADDRESS, modulo 2^P_ADDRESS_WIDTH. r_accepted_addr is the registered value before this edge.
  - Register O_PC_ADDRESS <= target, O_PC_ADDRESS_SELECT <= 1, O_PC_ADDRESS_SELECT_INCREMENT as above; O_VALID <= 0.
  - If O_PC_ENABLE is currently 0: O_PC_ENABLE <= 1, go to ST_REDIRECT.
  - If O_PC_ENABLE is currently 1 (first ST_HOLD cycle): O_PC_ENABLE <= 0, go to ST_DEFER.
- ST_DEFER: O_PC_ENABLE <= 1; go to ST_REDIRECT.
- ST_REDIRECT: O_PC_ENABLE <= 0; select outputs <= 0; go to ST_FETCH.
- Simultaneous events:
  - Redirect in ST_WAIT: returned data is discarded and no increment pulse is generated.
  - Redirect and handshake in the same cycle: the instruction counts as accepted and r_accepted_addr updates; the redirect is still taken.
- I_REDIRECT in ST_DEFER or ST_REDIRECT is a protocol violation: the bench asserts it never happens; the RTL ignores it.
- Every O_PC_ENABLE high pulse is exactly one cycle and is preceded by at least one low cycle.
- O_VALID never rises in the same cycle a redirect is sampled.

Test Plan:
- Reset, mem[0]=0x1234, mem[1]=0xABCD, I_READY=1 -> O_VALID 2 cycles after release with 0x1234 @0x0000; 0xABCD @0x0001 3 cycles later; I_PC_ADDRESS=0x0002 after second pulse.
- I_READY=0 for 5 cycles while valid -> O_INSTRUCTION/O_INSTRUCTION_ADDRESS stable, O_MEM_READ=0, exactly one O_PC_ENABLE pulse, pc stays 0x0001.
- Mode 0, addr 0x0040 in a later ST_HOLD cycle -> pc=0x0040; next valid has address 0x0040. Mode 2, addr 0x0030 -> next valid address 0x0031.
- Mode 1 after accepting instruction @0x0010 with disp 0xFFFC -> next fetch 0x000C. Accepted @0xFFFE with disp 0x0004 -> wraps to 0x0002.
- Redirect (mode 0, 0x0020) in first ST_HOLD cycle -> ST_DEFER path: one increment pulse, one low cycle, one redirect pulse; next valid @0x0020.
- Redirect in ST_WAIT -> no O_VALID for that fetch. I_RESET asserted in ST_WAIT -> all outputs 0, next fetch reads address 0x0000.
